// File: rtl/washing_machine_plant_model.sv
// washing_machine_plant_model
//
// Purpose: synthesizable emulation of a washing machine for hardware-in-the-loop
// and FPGA self-test of the appliance controller. Actuator commands go in,
// sensor readings come out. Plant dynamics advance once per prescaled tick.
//
// Ports:
//   clk                 system clock
//   reset               synchronous, active-high reset
//   water_valve         valve open command
//   heater              heater on command
//   drum_motor          motor on command
//   drain_pump          pump on command
//   door_lock           lock request
//   fault_inject        enables drum imbalance emulation
//   water_level         level sensor (0..1023)
//   temperature_adc     temperature sensor (AMBIENT_TEMP..1023)
//   motor_speed_sensor  tachometer (0..SPEED_MAX)
//   vibration_sensor    excessive vibration, latched until the drum stops
//   door_locked         lock sensor
//   dry_heat_fault      heater commanded with too little water (every clock)
//
// Door FSM
//   state      | meaning
//   UNLOCKED   | door free, door_locked=0
//   LOCKING    | actuator engaging, door_locked=0
//   LOCKED     | door held, door_locked=1; unlock refused while drum turns
//   UNLOCKING  | actuator releasing, door_locked still 1

module washing_machine_plant_model #(
    parameter int TICK_DIV        = 1000,
    parameter int FILL_RATE       = 8,
    parameter int DRAIN_RATE      = 16,
    parameter int HEAT_RATE       = 2,
    parameter int COOL_RATE       = 1,
    parameter int AMBIENT_TEMP    = 100,
    parameter int MIN_HEAT_LEVEL  = 128,
    parameter int ACCEL           = 10,
    parameter int DECEL           = 20,
    parameter int SPEED_MAX       = 1000,
    parameter int IMBALANCE_SPEED = 800,
    parameter int IMBALANCE_TICKS = 16,
    parameter int LOCK_DELAY      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       water_valve,
    input  logic       heater,
    input  logic       drum_motor,
    input  logic       drain_pump,
    input  logic       door_lock,
    input  logic       fault_inject,
    output logic [9:0] water_level,
    output logic [9:0] temperature_adc,
    output logic [9:0] motor_speed_sensor,
    output logic       vibration_sensor,
    output logic       door_locked,
    output logic       dry_heat_fault
);

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKING,
        LOCKED,
        UNLOCKING
    } door_state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int VW = $clog2(IMBALANCE_TICKS + 1);
    localparam int TW = $clog2(LOCK_DELAY + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [VW-1:0] VIB_LAST   = VW'(IMBALANCE_TICKS);
    // The entry tick counts as the first of the LOCK_DELAY ticks, so the
    // timer only has to cover the remaining LOCK_DELAY-1 ticks.
    localparam logic [TW-1:0] TMR_LAST   = TW'((LOCK_DELAY > 1) ? LOCK_DELAY - 2 : 0);

    localparam logic signed [11:0] FILL_S  = 12'(FILL_RATE);
    localparam logic signed [11:0] DRAIN_S = 12'(DRAIN_RATE);
    localparam logic [11:0] HEAT_U = 12'(HEAT_RATE);
    localparam logic [11:0] COOL_U = 12'(COOL_RATE);
    localparam logic [11:0] AMB_U  = 12'(AMBIENT_TEMP);
    localparam logic [11:0] MINH_U = 12'(MIN_HEAT_LEVEL);
    localparam logic [11:0] ACC_U  = 12'(ACCEL);
    localparam logic [11:0] DEC_U  = 12'(DECEL);
    localparam logic [11:0] SMAX_U = 12'(SPEED_MAX);
    localparam logic [11:0] ISPD_U = 12'(IMBALANCE_SPEED);
    localparam logic [9:0]  AMB_10 = 10'(AMBIENT_TEMP);
    localparam logic [9:0]  SMAX_10 = 10'(SPEED_MAX);

    logic [PW-1:0]        presc;
    logic                 tick;
    logic [VW-1:0]        vib_cnt;
    logic [VW-1:0]        vib_cnt_next;
    logic [TW-1:0]        lock_tmr;
    door_state_t          door_state;

    logic signed [11:0]   level_sum;
    logic [9:0]           level_next;
    logic [11:0]          temp_ext;
    logic [11:0]          heat_sum;
    logic [11:0]          cool_diff;
    logic [9:0]           temp_next;
    logic [11:0]          speed_ext;
    logic [11:0]          spd_up;
    logic [11:0]          spd_dn;
    logic [9:0]           speed_next;
    logic                 heat_ok;
    logic                 imb_qual;

    assign tick      = (presc == PRESC_LAST);
    assign temp_ext  = {2'b00, temperature_adc};
    assign heat_sum  = temp_ext + HEAT_U;
    assign cool_diff = temp_ext - COOL_U;
    assign speed_ext = {2'b00, motor_speed_sensor};
    assign spd_up    = speed_ext + ACC_U;
    assign spd_dn    = speed_ext - DEC_U;
    assign heat_ok   = heater && ({2'b00, water_level} >= MINH_U);
    assign imb_qual  = fault_inject && (speed_ext >= ISPD_U);

    always_comb begin
        level_sum = $signed({2'b00, water_level});
        if (water_valve) level_sum = level_sum + FILL_S;
        if (drain_pump)  level_sum = level_sum - DRAIN_S;
        if (level_sum < 12'sd0)         level_next = '0;
        else if (level_sum > 12'sd1023) level_next = 10'd1023;
        else                            level_next = level_sum[9:0];

        temp_next = temperature_adc;
        if (heat_ok) begin
            temp_next = (heat_sum > 12'd1023) ? 10'd1023 : heat_sum[9:0];
        end else if (temp_ext > AMB_U) begin
            // Compare before subtracting so a large COOL_RATE cannot wrap.
            temp_next = (temp_ext < AMB_U + COOL_U) ? AMB_10 : cool_diff[9:0];
        end

        if (drum_motor) speed_next = (spd_up > SMAX_U) ? SMAX_10 : spd_up[9:0];
        else            speed_next = (speed_ext < DEC_U) ? 10'd0 : spd_dn[9:0];

        if (!imb_qual)              vib_cnt_next = '0;
        else if (vib_cnt == VIB_LAST) vib_cnt_next = vib_cnt;
        else                        vib_cnt_next = vib_cnt + VW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc              <= '0;
            water_level        <= '0;
            temperature_adc    <= AMB_10;
            motor_speed_sensor <= '0;
            vibration_sensor   <= 1'b0;
            vib_cnt            <= '0;
            door_state         <= UNLOCKED;
            lock_tmr           <= '0;
            door_locked        <= 1'b0;
            dry_heat_fault     <= 1'b0;
        end else begin
            dry_heat_fault <= heater && ({2'b00, water_level} < MINH_U);
            presc          <= tick ? '0 : presc + PW'(1);

            if (tick) begin
                water_level        <= level_next;
                temperature_adc    <= temp_next;
                motor_speed_sensor <= speed_next;

                // A latched imbalance releases on the tick the drum comes to
                // rest, so speed and vibration read zero together.
                if (vibration_sensor && (speed_next == 10'd0)) begin
                    vibration_sensor <= 1'b0;
                    vib_cnt          <= '0;
                end else begin
                    vib_cnt <= vib_cnt_next;
                    if (vib_cnt_next == VIB_LAST) vibration_sensor <= 1'b1;
                end

                case (door_state)
                    UNLOCKED: begin
                        if (door_lock) begin
                            door_state <= LOCKING;
                            lock_tmr   <= '0;
                        end
                    end
                    LOCKING: begin
                        if (!door_lock) begin
                            door_state <= UNLOCKED;
                        end else if (lock_tmr >= TMR_LAST) begin
                            door_state  <= LOCKED;
                            door_locked <= 1'b1;
                        end else begin
                            lock_tmr <= lock_tmr + TW'(1);
                        end
                    end
                    LOCKED: begin
                        // Safety interlock: the drum must be stopped.
                        if (!door_lock && (motor_speed_sensor == 10'd0)) begin
                            door_state <= UNLOCKING;
                            lock_tmr   <= '0;
                        end
                    end
                    UNLOCKING: begin
                        if (door_lock) begin
                            door_state <= LOCKED;
                        end else if (lock_tmr >= TMR_LAST) begin
                            door_state  <= UNLOCKED;
                            door_locked <= 1'b0;
                        end else begin
                            lock_tmr <= lock_tmr + TW'(1);
                        end
                    end
                    default: begin
                        door_state  <= UNLOCKED;
                        door_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_washing_machine_plant_model.sv
// tb_washing_machine_plant_model
//
// Purpose: directed self-checking bench for washing_machine_plant_model with
// TICK_DIV=1 (one plant tick per clock). Inputs change and outputs are sampled
// on the falling edge; each tick(n) applies exactly n rising edges.

module tb_washing_machine_plant_model;

    logic       clk;
    logic       reset;
    logic       water_valve;
    logic       heater;
    logic       drum_motor;
    logic       drain_pump;
    logic       door_lock;
    logic       fault_inject;
    logic [9:0] water_level;
    logic [9:0] temperature_adc;
    logic [9:0] motor_speed_sensor;
    logic       vibration_sensor;
    logic       door_locked;
    logic       dry_heat_fault;

    int checks = 0;
    int errors = 0;

    washing_machine_plant_model #(
        .TICK_DIV(1)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .water_valve        (water_valve),
        .heater             (heater),
        .drum_motor         (drum_motor),
        .drain_pump         (drain_pump),
        .door_lock          (door_lock),
        .fault_inject       (fault_inject),
        .water_level        (water_level),
        .temperature_adc    (temperature_adc),
        .motor_speed_sensor (motor_speed_sensor),
        .vibration_sensor   (vibration_sensor),
        .door_locked        (door_locked),
        .dry_heat_fault     (dry_heat_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmd(input logic v, input logic h, input logic m,
                       input logic p, input logic l, input logic f);
        water_valve  = v;
        heater       = h;
        drum_motor   = m;
        drain_pump   = p;
        door_lock    = l;
        fault_inject = f;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_level"}, water_level, 0);
        check({tag, "_temp"},  temperature_adc, 100);
        check({tag, "_speed"}, motor_speed_sensor, 0);
        check({tag, "_vib"},   vibration_sensor, 0);
        check({tag, "_lock"},  door_locked, 0);
        check({tag, "_dry"},   dry_heat_fault, 0);
    endtask

    initial begin
        reset = 1'b1;
        cmd(0, 0, 0, 0, 0, 0);
        tick(3);
        check_reset_values("por");

        // Idle after reset release
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check("idle_level", water_level, 0);
            check("idle_temp",  temperature_adc, 100);
            check("idle_speed", motor_speed_sensor, 0);
            check("idle_vib",   vibration_sensor, 0);
            check("idle_lock",  door_locked, 0);
        end

        // Water fill, clamp at top, drain, clamp at bottom, net rate
        cmd(1, 0, 0, 0, 0, 0);
        tick(64);  check("fill_64", water_level, 512);
        tick(63);  check("fill_127", water_level, 1016);
        tick(1);   check("fill_clamp", water_level, 1023);
        tick(1);   check("fill_hold", water_level, 1023);
        check("fill_temp", temperature_adc, 100);
        cmd(0, 0, 0, 1, 0, 0);
        tick(63);  check("drain_63", water_level, 15);
        tick(1);   check("drain_clamp", water_level, 0);
        tick(2);   check("drain_hold", water_level, 0);
        cmd(1, 0, 0, 0, 0, 0);
        tick(64);  check("refill_512", water_level, 512);
        cmd(1, 0, 0, 1, 0, 0);
        tick(1);   check("net_rate", water_level, 504);
        cmd(0, 0, 0, 1, 0, 0);
        tick(31);  check("drain_8", water_level, 8);
        tick(1);   check("drain_zero", water_level, 0);

        // Heating: dry fault, heat, clamp, cool to ambient
        cmd(0, 1, 0, 0, 0, 0);
        tick(10);
        check("dry_temp", temperature_adc, 100);
        check("dry_fault", dry_heat_fault, 1);
        cmd(1, 0, 0, 0, 0, 0);
        tick(16);
        check("heat_fill", water_level, 128);
        check("dry_clear", dry_heat_fault, 0);
        cmd(0, 1, 0, 0, 0, 0);
        tick(1);   check("heat_1", temperature_adc, 102);
        check("heat_dry", dry_heat_fault, 0);
        tick(99);  check("heat_100", temperature_adc, 300);
        tick(361); check("heat_461", temperature_adc, 1022);
        tick(1);   check("heat_clamp", temperature_adc, 1023);
        tick(1);   check("heat_hold", temperature_adc, 1023);
        cmd(0, 0, 0, 0, 0, 0);
        tick(922); check("cool_922", temperature_adc, 101);
        tick(1);   check("cool_amb", temperature_adc, 100);
        tick(10);  check("cool_hold", temperature_adc, 100);

        // Door lock, interlock against spinning drum, unlock delay
        cmd(0, 0, 0, 0, 1, 0);
        tick(2);   check("lock_2", door_locked, 0);
        tick(1);   check("lock_3", door_locked, 1);
        cmd(0, 0, 1, 0, 1, 0);
        tick(50);  check("spin_500", motor_speed_sensor, 500);
        cmd(0, 0, 0, 0, 0, 0);
        tick(24);
        check("decel_24", motor_speed_sensor, 20);
        check("interlock", door_locked, 1);
        tick(1);
        check("decel_stop", motor_speed_sensor, 0);
        check("lock_at_stop", door_locked, 1);
        tick(2);   check("unlocking_2", door_locked, 1);
        tick(1);   check("unlocked", door_locked, 0);

        // Relock during UNLOCKING, then full unlock delay again
        cmd(0, 0, 0, 0, 1, 0);
        tick(3);   check("relock_3", door_locked, 1);
        cmd(0, 0, 0, 0, 0, 0);
        tick(1);   check("relock_unl", door_locked, 1);
        cmd(0, 0, 0, 0, 1, 0);
        tick(1);   check("relock_back", door_locked, 1);
        cmd(0, 0, 0, 0, 0, 0);
        tick(2);   check("relock_unl2", door_locked, 1);
        tick(1);   check("relock_free", door_locked, 0);

        // Abort LOCKING
        cmd(0, 0, 0, 0, 1, 0);
        tick(1);
        cmd(0, 0, 0, 0, 0, 0);
        tick(4);   check("lock_abort", door_locked, 0);

        // Imbalance: count, latch, release at standstill
        cmd(0, 0, 1, 0, 0, 1);
        tick(80);
        check("imb_speed80", motor_speed_sensor, 800);
        check("imb_vib80", vibration_sensor, 0);
        tick(15);  check("imb_vib95", vibration_sensor, 0);
        tick(1);   check("imb_vib96", vibration_sensor, 1);
        tick(4);   check("spd_max", motor_speed_sensor, 1000);
        tick(1);   check("spd_clamp", motor_speed_sensor, 1000);
        cmd(0, 0, 0, 0, 0, 0);
        tick(49);
        check("vib_latch_spd", motor_speed_sensor, 20);
        check("vib_latched", vibration_sensor, 1);
        tick(1);
        check("vib_stop_spd", motor_speed_sensor, 0);
        check("vib_release", vibration_sensor, 0);
        cmd(0, 0, 1, 0, 0, 0);
        tick(120);
        check("nofault_spd", motor_speed_sensor, 1000);
        check("nofault_vib", vibration_sensor, 0);

        // Counter clears on a non-qualifying tick
        cmd(0, 0, 1, 0, 0, 1);
        tick(10);  check("cnt_10", vibration_sensor, 0);
        cmd(0, 0, 1, 0, 0, 0);
        tick(1);
        cmd(0, 0, 1, 0, 0, 1);
        tick(15);  check("cnt_restart15", vibration_sensor, 0);
        tick(1);   check("cnt_restart16", vibration_sensor, 1);
        cmd(0, 0, 1, 0, 0, 0);
        tick(5);   check("vib_fi_drop", vibration_sensor, 1);

        // Mid-run reset with everything active
        cmd(1, 1, 1, 0, 1, 0);
        tick(48);
        check("pre_level", water_level, 512);
        cmd(0, 1, 0, 0, 1, 0);
        tick(25);
        check("pre_level2", water_level, 512);
        check("pre_speed", motor_speed_sensor, 500);
        check("pre_temp", temperature_adc, 246);
        check("pre_lock", door_locked, 1);
        check("pre_vib", vibration_sensor, 1);
        reset = 1'b1;
        cmd(1, 1, 1, 1, 1, 1);
        tick(1);
        check_reset_values("midrst");
        tick(2);
        check_reset_values("midrst_hold");
        reset = 1'b0;
        cmd(0, 0, 0, 0, 0, 0);
        tick(1);
        check_reset_values("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
